// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle FSM control unit with MEM latency and I/O wait states
module multicycle_control_unit #(
  parameter int OPCODE_W    = 6,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                in_valid,
  input  logic                out_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          RegisterDST,
  output logic [1:0]          Jump,
  output logic [1:0]          memtoReg,
  output logic                Branch,
  output logic                ALUSrc,
  output logic                regWrite,
  output logic                memWrite,
  output logic                memRead,
  output logic [2:0]          Alu_op,
  output logic                halt,
  output logic                input_flag,
  output logic                output_flag,
  output logic                in_ack,
  output logic [2:0]          state
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
    WB = 3'd4, IN_WAIT = 3'd5, OUT_WAIT = 3'd6, HALTED = 3'd7
  } state_t;
  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);
  state_t              r_state, w_next;
  logic [OPCODE_W-1:0] r_op;
  logic [3:0]          r_cnt, w_cnt;
  function automatic logic is_op(input logic [OPCODE_W-1:0] o, input int n);
    return o == OPCODE_W'(n);
  endfunction
  logic w_r, w_lw, w_sw, w_addi, w_subi, w_beq;
  assign w_r    = is_op(r_op, 0);
  assign w_lw   = is_op(r_op, 1);
  assign w_sw   = is_op(r_op, 2);
  assign w_addi = is_op(r_op, 3);
  assign w_subi = is_op(r_op, 4);
  assign w_beq  = is_op(r_op, 5);
  assign state  = reset ? 3'd0 : r_state;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FETCH;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (r_state == DECODE) r_op <= opcode;
    end
  end
  // Reset forces every control low combinationally, even mid-access.
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    ir_write = 1'b0;
    pc_write = 1'b0;
    RegisterDST = 2'b00;
    Jump = 2'b00;
    memtoReg = 2'b00;
    Branch = 1'b0;
    ALUSrc = 1'b0;
    regWrite = 1'b0;
    memWrite = 1'b0;
    memRead = 1'b0;
    Alu_op = 3'b000;
    halt = 1'b0;
    input_flag = 1'b0;
    output_flag = 1'b0;
    in_ack = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next = DECODE;
        end
        DECODE: begin
          w_next = FETCH;
          if (is_op(opcode, 9)) begin
            Jump = 2'b01;
            pc_write = 1'b1;
          end else if (is_op(opcode, 10)) begin
            Jump = 2'b10;
            RegisterDST = 2'b10;
            pc_write = 1'b1;
          end else if (is_op(opcode, 11)) begin
            Jump = 2'b01;
            pc_write = 1'b1;
            regWrite = 1'b1;
            RegisterDST = 2'b10;
            memtoReg = 2'b10;
          end else if (&opcode) w_next = HALTED;
          else if (is_op(opcode, 12)) w_next = IN_WAIT;
          else if (is_op(opcode, 13)) w_next = OUT_WAIT;
          else if (opcode <= OPCODE_W'(5)) w_next = EXEC;
        end
        EXEC: begin
          w_cnt = '0;
          w_next = FETCH;
          if (w_r) begin
            Alu_op = 3'b100;
            w_next = WB;
          end else if (w_addi || w_subi) begin
            Alu_op = w_subi ? 3'b001 : 3'b000;
            ALUSrc = 1'b1;
            w_next = WB;
          end else if (w_lw || w_sw) begin
            ALUSrc = 1'b1;
            w_next = MEM;
          end else if (w_beq) begin
            Branch = 1'b1;
            Alu_op = 3'b011;
            pc_write = zero;
          end
        end
        MEM: begin
          ALUSrc = 1'b1;
          memRead = w_lw;
          memWrite = w_sw;
          w_next = r_cnt == LAST ? (w_lw ? WB : FETCH) : MEM;
          w_cnt = r_cnt == LAST ? r_cnt : r_cnt + 4'd1;
        end
        WB: begin
          regWrite = 1'b1;
          RegisterDST = w_r ? 2'b01 : 2'b00;
          memtoReg = w_lw ? 2'b01 : 2'b00;
          w_next = FETCH;
        end
        IN_WAIT: begin
          input_flag = 1'b1;
          regWrite = in_valid;
          RegisterDST = in_valid ? 2'b11 : 2'b00;
          memtoReg = in_valid ? 2'b11 : 2'b00;
          in_ack = in_valid;
          w_next = in_valid ? FETCH : IN_WAIT;
        end
        OUT_WAIT: begin
          output_flag = 1'b1;
          w_next = out_ready ? FETCH : OUT_WAIT;
        end
        HALTED: halt = 1'b1;
        default: w_next = FETCH;
      endcase
    end
  end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameters SHALL be: OPCODE_W, default 6, opcode width (>=6); MEM_LATENCY, default 1, cycles memRead/memWrite held per access (1..15).
REQ-002 Ports SHALL be, in order:
  clock  in  1  single clock, all state updates on rising edge
  reset  in  1  synchronous, active-high
  opcode  in  OPCODE_W  instruction opcode field, valid during DECODE
  zero  in  1  ALU zero flag, sampled in EXEC of beq
  in_valid  in  1  input device has data
  out_ready  in  1  output device accepts data
  ir_write  out  1  load instruction register
  pc_write  out  1  update PC (source selected by Jump/Branch)
  RegisterDST  out  2  write-register select
  Jump  out  2  00 none, 01 target, 10 register
  memtoReg  out  2  writeback source select
  Branch, ALUSrc, regWrite, memWrite, memRead  out  1 each  datapath controls
  Alu_op  out  3  ALU operation
  halt  out  1  processor halted
  input_flag, output_flag  out  1 each  I/O instruction in progress
  in_ack  out  1  input data consumed this cycle
  state  out  3  current FSM state (debug)
REQ-003 Clock SHALL be named clock, reset SHALL be named reset; one clock domain; reset synchronous, active-high.

Function
REQ-004 Opcode map SHALL be (low 6 bits, upper bits zero): R 0, lw 1, sw 2, addi 3, subi 4, beq 5, j 9, jr 10, jal 11, in 12, out 13; halt = all OPCODE_W bits 1; anything else = NOP.
REQ-005 States/encoding SHALL be FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, IN_WAIT 5, OUT_WAIT 6, HALTED 7; state output = current state.
REQ-006 Every output not listed for a state/cycle SHALL be 0; outputs are combinational from state, latched opcode, zero, in_valid, out_ready.
REQ-007 FETCH: ir_write=1, pc_write=1 (PC+1); next DECODE.
REQ-008 DECODE: opcode latched into internal op_q; j: Jump=01, pc_write=1, next FETCH; jr: Jump=10, RegisterDST=10, pc_write=1, next FETCH; jal: Jump=01, pc_write=1, regWrite=1, RegisterDST=10, memtoReg=10, next FETCH; halt -> HALTED; in -> IN_WAIT; out -> OUT_WAIT; NOP -> FETCH; R/lw/sw/addi/subi/beq -> EXEC.
REQ-009 EXEC (uses op_q): R: Alu_op=100, ALUSrc=0 -> WB; addi: Alu_op=000, ALUSrc=1 -> WB; subi: Alu_op=001, ALUSrc=1 -> WB; lw/sw: Alu_op=000, ALUSrc=1 -> MEM; beq: Branch=1, Alu_op=011, pc_write=zero -> FETCH.
REQ-010 MEM: lw asserts memRead, sw asserts memWrite, ALUSrc=1, for exactly MEM_LATENCY consecutive cycles via a 4-bit counter cleared on MEM entry; after last cycle lw -> WB, sw -> FETCH.
REQ-011 WB: regWrite=1; R: RegisterDST=01, memtoReg=00; addi/subi: RegisterDST=00, memtoReg=00; lw: RegisterDST=00, memtoReg=01; next FETCH.
REQ-012 IN_WAIT: input_flag=1 every cycle; when in_valid=1: regWrite=1, RegisterDST=11, memtoReg=11, in_ack=1 in that same cycle, next FETCH; else stay.
REQ-013 OUT_WAIT: output_flag=1 every cycle; when out_ready=1 next FETCH; else stay.
REQ-014 HALTED: halt=1, all other outputs 0, remains until reset; opcode, in_valid, out_ready ignored.
REQ-015 Instruction latency SHALL be: j/jr/jal/NOP 2 cycles; beq 3; R/addi/subi 4; sw 3+MEM_LATENCY; lw 4+MEM_LATENCY; in/out 3 + wait cycles.
REQ-016 in_valid/out_ready asserted outside IN_WAIT/OUT_WAIT SHALL have no effect.

Reset
REQ-017 reset=1 at a clock edge SHALL force state=FETCH, op_q=0, counter=0, regardless of current state (incl. mid-MEM, wait states, HALTED).
REQ-018 While reset=1 every output except state SHALL be 0; state reads 0; first cycle after deassertion is FETCH.

Verification
REQ-019 addi (3): states 0,1,2,4 -> ALUSrc=1 in EXEC, regWrite=1 only in WB, back to FETCH on cycle 5.
REQ-020 lw, MEM_LATENCY=2: memRead=1 exactly 2 cycles, then WB with memtoReg=01, regWrite=1; total 6 cycles.
REQ-021 beq with zero=0 -> pc_write=0, Branch=1 in EXEC; repeat with zero=1 -> pc_write=1.
REQ-022 in (12), in_valid raised 3 cycles after IN_WAIT entry -> input_flag=1 4 cycles, in_ack=1 single cycle with regWrite=1, RegisterDST=11.
REQ-023 halt (63) -> halt=1 persistently, other outputs 0; reset pulse -> state 0 next cycle, halt=0.
REQ-024 opcode 62 (undefined) -> FETCH, DECODE, FETCH, no regWrite/memWrite/pc_write in DECODE; reset asserted mid-MEM of sw -> memWrite drops to 0 immediately, FETCH next.
